// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller:
// segment bit positions and the active-high hex glyph table.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Bits g..a, indexed by nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-high a..g segment pattern.
// Polarity is applied by the instantiating scan controller.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with dwell blanking,
// per-digit dp/blank masks and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  input  logic                  live,
  input  logic                  lz_blank,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic [2:0]            digit_idx,
  output logic                  frame_tick
);

  localparam int PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [2:0]    DIG_LAST  = 3'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = {8{ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW != 0}};

  logic [PW-1:0]         pre_q, pre_d;
  logic [2:0]            dig_q, dig_d;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q, blank_q;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  tick_q, tick_d;

  logic                  wrap, last_dig, lit;
  logic [3:0]            nib;
  logic [6:0]            dec;
  logic                  dp_sel, dark, hi_zero;
  logic [DIGITS-1:0]     an_act, lz_dark;
  logic [7:0]            seg_act;

  seg7_hex_decoder u_dec (
    .nib_i (nib),
    .seg_o (dec)
  );

  always_comb begin
    wrap     = (pre_q == PRE_LAST);
    last_dig = (dig_q == DIG_LAST);
    pre_d    = wrap ? '0 : pre_q + 1'b1;
    dig_d    = dig_q;
    if (wrap) dig_d = last_dig ? 3'd0 : dig_q + 3'd1;
    tick_d   = wrap & last_dig;
  end

  // Walk from the top digit down; a digit is a leading zero
  // only while every nibble above it is also zero.
  always_comb begin
    hi_zero = 1'b1;
    lz_dark = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (data_q[4*i +: 4] == 4'h0);
      if (i != 0) lz_dark[i] = lz_blank & hi_zero;
    end
  end

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    dark   = 1'b0;
    an_act = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == 3'(i)) begin
        nib       = data_q[4*i +: 4];
        dp_sel    = dp_q[i];
        dark      = blank_q[i] | lz_dark[i];
        an_act[i] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_act = '0;
    if (!dark) begin
      seg_act[SEG_G:SEG_A] = dec;
      seg_act[SEG_DP]      = dp_sel;
    end
    lit   = (pre_q >= PRE_BLANK);
    seg_d = lit ? (seg_act ^ SEG_OFF) : SEG_OFF;
    an_d  = lit ? (an_act ^ AN_OFF) : AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      dig_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      if (live || load) begin
        data_q  <= data_in;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign digit_idx  = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed vector bench for seg7_scan_ctrl
// (4 digits, dwell 8, blank 2, active-low).
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic        live;
  logic        lz_blank;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t vt [22];

  seg7_scan_ctrl #(
    .DIGITS      (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .live       (live),
    .lz_blank   (lz_blank),
    .SEG        (SEG),
    .AN         (AN),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] an);
    int n;
    n = 0;
    while (AN !== an && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic apply(input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl, input logic lz);
    @(negedge clk);
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    lz_blank = lz;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Called just after rst is released on a falling edge
  task automatic restart_check(input string nm);
    @(negedge clk);
    chk({nm, "_blank0"}, {28'd0, AN}, 32'hF);
    @(negedge clk);
    chk({nm, "_blank1"}, {28'd0, AN}, 32'hF);
    @(negedge clk);
    chk({nm, "_dig0"}, {20'd0, AN, SEG}, {20'd0, 4'b1110, 8'hC0});
    repeat (4) @(negedge clk);
    chk({nm, "_idx7"}, {29'd0, digit_idx}, 32'd0);
    @(negedge clk);
    chk({nm, "_idx8"}, {29'd0, digit_idx}, 32'd1);
  endtask

  initial begin
    int n;
    vt[0]  = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'b1110, 8'hA1};
    vt[1]  = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'b1101, 8'hC6};
    vt[2]  = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'b1011, 8'h83};
    vt[3]  = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'b0111, 8'h88};
    vt[4]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'b0111, 8'hFF};
    vt[5]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'b1011, 8'hFF};
    vt[6]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'b1101, 8'hF8};
    vt[7]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'b1110, 8'hC0};
    vt[8]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'b1110, 8'hC0};
    vt[9]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'b1101, 8'hFF};
    vt[10] = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'b0111, 8'hFF};
    vt[11] = '{16'h1234, 4'h4, 4'h1, 1'b0, 4'b1011, 8'h24};
    vt[12] = '{16'h1234, 4'h4, 4'h1, 1'b0, 4'b1110, 8'hFF};
    vt[13] = '{16'h1234, 4'h4, 4'h1, 1'b0, 4'b1101, 8'hB0};
    vt[14] = '{16'h1234, 4'h4, 4'h1, 1'b0, 4'b0111, 8'hF9};
    vt[15] = '{16'h0070, 4'h0, 4'h0, 1'b0, 4'b0111, 8'hC0};
    vt[16] = '{16'h0800, 4'h0, 4'h0, 1'b1, 4'b1011, 8'h80};
    vt[17] = '{16'h0800, 4'h0, 4'h0, 1'b1, 4'b0111, 8'hFF};
    vt[18] = '{16'h0800, 4'h0, 4'h0, 1'b1, 4'b1101, 8'hC0};
    vt[19] = '{16'hEF00, 4'h0, 4'h0, 1'b0, 4'b1011, 8'h8E};
    vt[20] = '{16'hEF00, 4'h0, 4'h0, 1'b0, 4'b0111, 8'h86};
    vt[21] = '{16'hEF00, 4'h8, 4'h0, 1'b0, 4'b0111, 8'h06};

    rst      = 1'b1;
    data_in  = 16'h0;
    dp_in    = 4'h0;
    blank_in = 4'h0;
    load     = 1'b0;
    live     = 1'b0;
    lz_blank = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out", {16'd0, AN, SEG, 1'b0, digit_idx, frame_tick},
        {16'd0, 4'hF, 8'hFF, 1'b0, 3'd0, 1'b0});
    rst = 1'b0;
    restart_check("release");

    foreach (vt[i]) begin
      apply(vt[i].data, vt[i].dp, vt[i].bl, vt[i].lz);
      wait_an(vt[i].an);
      chk($sformatf("vec%0d", i), {20'd0, AN, SEG},
          {20'd0, vt[i].an, vt[i].seg});
    end

    // Capture: hold without load, then live tracking
    apply(16'h1234, 4'h0, 4'h0, 1'b0);
    data_in = 16'h5678;
    repeat (2) @(negedge clk);
    wait_an(4'b1110);
    chk("hold_no_load", {24'd0, SEG}, {24'd0, 8'h99});
    live = 1'b1;
    repeat (2) @(negedge clk);
    wait_an(4'b1110);
    chk("live_track", {24'd0, SEG}, {24'd0, 8'h80});
    data_in = 16'h9ABC;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    live    = 1'b0;
    data_in = 16'h0000;
    @(negedge clk);
    wait_an(4'b1110);
    chk("live_and_load", {24'd0, SEG}, {24'd0, 8'hC6});

    // Frame tick timing and dwell blanking
    n = 0;
    while (frame_tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", {31'd0, frame_tick}, 32'd1);
    chk("tick_idx", {29'd0, digit_idx}, 32'd0);
    chk("tick_an", {28'd0, AN}, 32'h7);
    @(negedge clk);
    chk("tick_width", {31'd0, frame_tick}, 32'd0);
    chk("dwell_blank0", {28'd0, AN}, 32'hF);
    @(negedge clk);
    chk("dwell_blank1", {28'd0, AN}, 32'hF);
    @(negedge clk);
    chk("dwell_lit", {28'd0, AN}, 32'hE);
    n = 3;
    while (frame_tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("tick_period", n, 32'd32);

    // Asynchronous reset in the middle of a lit dwell
    wait_an(4'b1101);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {20'd0, AN, SEG}, {20'd0, 4'hF, 8'hFF});
    chk("rst_idx", {28'd0, digit_idx, frame_tick}, 32'd0);
    @(negedge clk);
    chk("rst_held", {20'd0, AN, SEG}, {20'd0, 4'hF, 8'hFF});
    rst = 1'b0;
    restart_check("midscan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
